// File: rtl/fp_addsub_arbiter_if.sv
// Requester and FP-unit signal bundle for the shared add/sub arbiter.
// slave = arbiter side, master = requesters plus FP unit (or a bench driving both).
interface fp_addsub_arbiter_if;
  logic        req0, req1;
  logic [31:0] a0, b0, a1, b1;
  logic        op0, op1;
  logic        gnt0, gnt1;
  logic        fu_load, fu_en;
  logic [31:0] fu_a, fu_b;
  logic        fu_op;
  logic        fu_ready;
  logic [31:0] fu_sum;
  logic [31:0] res;
  logic        res_valid, res_id, res_timeout;
  logic        busy;

  modport slave (
    input  req0, req1, a0, b0, a1, b1, op0, op1, fu_ready, fu_sum,
    output gnt0, gnt1, fu_load, fu_en, fu_a, fu_b, fu_op,
           res, res_valid, res_id, res_timeout, busy
  );

  modport master (
    output req0, req1, a0, b0, a1, b1, op0, op1, fu_ready, fu_sum,
    input  gnt0, gnt1, fu_load, fu_en, fu_a, fu_b, fu_op,
           res, res_valid, res_id, res_timeout, busy
  );
endinterface

// File: rtl/fp_addsub_arbiter.sv
// Round-robin sharing of one FP add/sub unit between two requesters, with a
// watchdog that returns a quiet NaN if the unit never reports ready.
module fp_addsub_arbiter #(
  parameter int TIMEOUT = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  fp_addsub_arbiter_if.slave      bus
);
  localparam int CW = $clog2(TIMEOUT);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
  localparam logic [31:0]   QNAN     = 32'h7FC0_0000;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN, S_RESP} state_e;

  state_e        state_q, state_d;
  logic          ptr_q, ptr_d;
  logic [31:0]   fu_a_q, fu_a_d, fu_b_q, fu_b_d;
  logic          fu_op_q, fu_op_d;
  logic [31:0]   res_q, res_d;
  logic          res_id_q, res_id_d;
  logic          res_tmo_q, res_tmo_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          win, gnt0, gnt1;

  // ptr_q names the requester that wins a tie
  assign win = (bus.req0 && bus.req1) ? ptr_q : bus.req1;

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    fu_a_d    = fu_a_q;
    fu_b_d    = fu_b_q;
    fu_op_d   = fu_op_q;
    res_d     = res_q;
    res_id_d  = res_id_q;
    res_tmo_d = res_tmo_q;
    cnt_d     = cnt_q;
    gnt0      = 1'b0;
    gnt1      = 1'b0;
    case (state_q)
      S_IDLE: begin
        // rst gate keeps grants low while reset is held
        if ((bus.req0 || bus.req1) && rst) begin
          gnt0     = ~win;
          gnt1     = win;
          fu_a_d   = win ? bus.a1  : bus.a0;
          fu_b_d   = win ? bus.b1  : bus.b0;
          fu_op_d  = win ? bus.op1 : bus.op0;
          res_id_d = win;
          ptr_d    = ~win;
          state_d  = S_LOAD;
        end
      end
      S_LOAD: begin
        // fu_ready here may be left over from the previous operation
        cnt_d   = '0;
        state_d = S_RUN;
      end
      S_RUN: begin
        cnt_d = cnt_q + CW'(1);
        if (bus.fu_ready) begin
          res_d     = bus.fu_sum;
          res_tmo_d = 1'b0;
          state_d   = S_RESP;
        end else if (cnt_q == CNT_LAST) begin
          res_d     = QNAN;
          res_tmo_d = 1'b1;
          state_d   = S_RESP;
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      ptr_q     <= 1'b0;
      fu_a_q    <= '0;
      fu_b_q    <= '0;
      fu_op_q   <= 1'b0;
      res_q     <= '0;
      res_id_q  <= 1'b0;
      res_tmo_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      fu_a_q    <= fu_a_d;
      fu_b_q    <= fu_b_d;
      fu_op_q   <= fu_op_d;
      res_q     <= res_d;
      res_id_q  <= res_id_d;
      res_tmo_q <= res_tmo_d;
      cnt_q     <= cnt_d;
    end
  end

  assign bus.gnt0        = gnt0;
  assign bus.gnt1        = gnt1;
  assign bus.fu_load     = (state_q == S_LOAD);
  assign bus.fu_en       = (state_q == S_LOAD) || (state_q == S_RUN);
  assign bus.fu_a        = fu_a_q;
  assign bus.fu_b        = fu_b_q;
  assign bus.fu_op       = fu_op_q;
  assign bus.res         = res_q;
  assign bus.res_valid   = (state_q == S_RESP);
  assign bus.res_id      = res_id_q;
  assign bus.res_timeout = res_tmo_q;
  assign bus.busy        = (state_q != S_IDLE);
endmodule
